// File: rtl/full_adder_sync.sv
// ---------------------------------------------------------------------------
// full_adder_sync
//   Registered ripple-carry adder. On each rising clock edge with in_valid
//   high, captures {c,s} = a + b + cin (WIDTH+1-bit unsigned result). With
//   WIDTH=1 this is the classic 1-bit full adder with registered outputs.
//   One cycle of latency, one result per clock, no backpressure. No input
//   reaches an output without passing through a register.
//
// Parameters
//   WIDTH      operand width in bits (>= 1)
//
// Ports
//   clk        in   1      rising-edge clock
//   rst        in   1      synchronous reset, active-high (priority over in_valid)
//   in_valid   in   1      qualifies a/b/cin for capture this cycle
//   a          in   WIDTH  operand A, unsigned
//   b          in   WIDTH  operand B, unsigned
//   cin        in   1      carry in
//   s          out  WIDTH  registered sum bits (wrap on overflow)
//   c          out  1      registered carry out (2^WIDTH bit)
//   out_valid  out  1      s/c were produced from a valid input last cycle
// ---------------------------------------------------------------------------
module full_adder_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             c,
  output logic             out_valid
);

  // Carry chain: w_k[i] is the carry into bit i, w_k[WIDTH] is the carry out.
  logic [WIDTH:0]   w_k;
  logic [WIDTH-1:0] w_sum;

  logic [WIDTH-1:0] r_s;
  logic             r_c;
  logic             r_valid;

  // Explicit per-bit full-adder cells so the ripple structure is visible in
  // the netlist rather than left to a '+' operator.
  always_comb begin
    // NOTE: every combinational output gets a default before any conditional
    // or loop assignment, so no path leaves it unassigned and no latch forms.
    w_k    = '0;
    w_sum  = '0;
    w_k[0] = cin;
    for (int i = 0; i < WIDTH; i++) begin
      w_sum[i]  = a[i] ^ b[i] ^ w_k[i];
      w_k[i+1]  = (a[i] & b[i]) | (w_k[i] & (a[i] ^ b[i]));
    end
  end

  // Output register. Reset wins over in_valid, so a result presented in a
  // reset cycle is discarded. With in_valid low the sum/carry hold their last
  // value and only the valid flag drops.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (rst) begin
      r_s     <= '0;
      r_c     <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_s <= w_sum;
        r_c <= w_k[WIDTH];
      end
    end
  end

  assign s         = r_s;
  assign c         = r_c;
  assign out_valid = r_valid;

endmodule

// File: tb/tb_full_adder_sync.sv
// ---------------------------------------------------------------------------
// tb_full_adder_sync
//   Self-checking bench for full_adder_sync. Three instances (WIDTH 1, 4, 8)
//   share clk, rst, in_valid and cin; each has its own operands. Each step
//   drives inputs on the falling edge, pushes the expected registered state
//   (from an arithmetic reference model) onto a scoreboard queue, then pops
//   and compares shortly after the next rising edge.
// ---------------------------------------------------------------------------
module tb_full_adder_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       cin = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [7:0] a8 = '0, b8 = '0;

  logic [0:0] s1;
  logic [3:0] s4;
  logic [7:0] s8;
  logic       c1, c4, c8;
  logic       v1, v4, v8;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [0:0] s1;
    logic       c1;
    logic [3:0] s4;
    logic       c4;
    logic [7:0] s8;
    logic       c8;
    logic       v;
  } exp_t;

  exp_t sb_q[$];
  exp_t model;   // reference registered state, advanced per step

  always #5 clk = ~clk;

  full_adder_sync #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1), .cin(cin),
    .s(s1), .c(c1), .out_valid(v1)
  );
  full_adder_sync #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4), .cin(cin),
    .s(s4), .c(c4), .out_valid(v4)
  );
  full_adder_sync #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8), .cin(cin),
    .s(s8), .c(c8), .out_valid(v8)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus plus its scoreboard comparison.
  task automatic step(input string tag, input logic r, input logic v, input logic ci,
                      input logic [0:0] xa1, input logic [0:0] xb1,
                      input logic [3:0] xa4, input logic [3:0] xb4,
                      input logic [7:0] xa8, input logic [7:0] xb8);
    logic [1:0] t1;
    logic [4:0] t4;
    logic [8:0] t8;
    exp_t       e;
    @(negedge clk);
    rst = r; in_valid = v; cin = ci;
    a1 = xa1; b1 = xb1; a4 = xa4; b4 = xb4; a8 = xa8; b8 = xb8;
    t1 = 2'(xa1) + 2'(xb1) + 2'(ci);
    t4 = 5'(xa4) + 5'(xb4) + 5'(ci);
    t8 = 9'(xa8) + 9'(xb8) + 9'(ci);
    if (r) begin
      model = '0;
    end else begin
      model.v = v;
      if (v) begin
        {model.c1, model.s1} = t1;
        {model.c4, model.s4} = t4;
        {model.c8, model.s8} = t8;
      end
    end
    sb_q.push_back(model);
    @(posedge clk);
    #1;
    n_checks++;
    assert (sb_q.size() != 0) else begin
      n_errors++;
      $error("FAIL %s.sb_empty: observed 0 entries expected 1", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check({tag, ".s1"}, 8'(s1), 8'(e.s1));
      check({tag, ".c1"}, 8'(c1), 8'(e.c1));
      check({tag, ".s4"}, 8'(s4), 8'(e.s4));
      check({tag, ".c4"}, 8'(c4), 8'(e.c4));
      check({tag, ".s8"}, s8, e.s8);
      check({tag, ".c8"}, 8'(c8), 8'(e.c8));
      check({tag, ".v1"}, 8'(v1), 8'(e.v));
      check({tag, ".v4"}, 8'(v4), 8'(e.v));
      check({tag, ".v8"}, 8'(v8), 8'(e.v));
    end
  endtask

  initial begin
    model = '0;

    // Reset for two cycles with random valid inputs, then release idle.
    for (int i = 0; i < 2; i++)
      step("reset", 1'b1, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom),
           4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom));
    for (int i = 0; i < 2; i++)
      step("post_reset_idle", 1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom),
           4'($urandom), 4'($urandom), 8'($urandom), 8'($urandom));

    // Explicit constant checks of the 1-bit truth table, independent of model.
    for (int v = 0; v < 8; v++) begin
      logic [2:0] vec;
      logic [1:0] cs_exp;
      vec = 3'(v);
      // {c,s} from the table: 000->00 001->01 010->01 011->10 100->01 101->10 110->10 111->11
      case (vec)
        3'b000:                 cs_exp = 2'b00;
        3'b001, 3'b010, 3'b100: cs_exp = 2'b01;
        3'b011, 3'b101, 3'b110: cs_exp = 2'b10;
        default:                cs_exp = 2'b11;
      endcase
      step("truth", 1'b0, 1'b1, vec[0], vec[2], vec[1],
           {3'b0, vec[2]}, {3'b0, vec[1]}, {7'b0, vec[2]}, {7'b0, vec[1]});
      check("truth.tbl_s", 8'(s1), 8'(cs_exp[0]));
      check("truth.tbl_c", 8'(c1), 8'(cs_exp[1]));
    end

    // Hold: 1+1+1 captured, then idle with zeros -> values hold, valid drops.
    step("hold_load", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'h1, 4'h1, 8'h01, 8'h01);
    step("hold_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 8'h00, 8'h00);
    check("hold.s1_const", 8'(s1), 8'h01);
    check("hold.c1_const", 8'(c1), 8'h01);
    check("hold.v_const",  8'(v1), 8'h00);

    // Wrap at WIDTH=4 (also exercises the 8-bit boundary).
    step("wrap_f_1", 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'hF, 4'h1, 8'hFF, 8'h01);
    check("wrap_f_1.s4_const", 8'(s4), 8'h00);
    check("wrap_f_1.c4_const", 8'(c4), 8'h01);
    step("wrap_f_f_1", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'hF, 4'hF, 8'hFF, 8'hFF);
    check("wrap_f_f_1.s4_const", 8'(s4), 8'h0F);
    check("wrap_f_f_1.c4_const", 8'(c4), 8'h01);

    // Reset priority over a valid input on the same edge.
    step("rst_prio", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h1, 4'h1, 8'h01, 8'h01);
    check("rst_prio.s1_const", 8'(s1), 8'h00);
    check("rst_prio.v_const",  8'(v1), 8'h00);

    // Back-to-back random stream, occasional idle cycles mixed in.
    for (int i = 0; i < 1000; i++)
      step("rand", 1'b0, ($urandom_range(0, 9) != 0), 1'($urandom),
           1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
           8'($urandom), 8'($urandom));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
